// File: rtl/png_scan_ser.sv
// PNG raster serializer: pulls per-line 8-pixel words from the stripe FIFO and
// emits raw scanline bytes (filter byte 0x00, then pixel-major channel bytes).
module png_scan_ser #(
   parameter int unsigned LINES = 8,
   parameter int unsigned CH    = 4,
   parameter int unsigned PW    = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_start,
   input  logic [PW-1:0]          pic_width,
   input  logic [PW-1:0]          pic_height,
   input  logic [2:0]             ch_num,
   input  logic [LINES-1:0]       sdata_vld,
   output logic [LINES-1:0]       sdata_rdy,
   input  logic [LINES*CH*64-1:0] sdata,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [7:0]             out_data,
   output logic                   out_sol,
   output logic                   out_done,
   output logic                   busy
);

   localparam int unsigned LW = $clog2(LINES);
   localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

   typedef logic [CH-1:0][7:0][7:0] lane_t;
   typedef enum logic [2:0] {S_IDLE, S_FILT, S_LOAD, S_EMIT, S_DONE} state_t;

   state_t          state_q;
   logic [PW-1:0]   w_q, h_q, wcnt_q, ycnt_q;
   logic [2:0]      ch_q;
   logic [LW-1:0]   lcnt_q;
   logic [2:0]      pcnt_q;
   logic [CW-1:0]   ccnt_q;
   lane_t           hold_q;

   lane_t [LINES-1:0] sdata_a;
   assign sdata_a = sdata;

   logic [2:0]      ch_clamp_c;
   logic [CW-1:0]   ch_last_c;
   logic [PW-1:0]   last_word_c;
   logic [2:0]      last_px_c;
   logic            word_end_c, line_end_c, frame_end_c;
   logic [2:0]      pcnt_d;
   logic [CW-1:0]   ccnt_d;

   // Word/line boundary detection and next pixel/channel position
   always_comb begin
      ch_clamp_c  = ((ch_num == 3'd0) || (32'(ch_num) > CH)) ? 3'(CH) : ch_num;
      ch_last_c   = CW'(ch_q - 3'd1);
      last_word_c = (w_q - PW'(1)) >> 3;
      last_px_c   = (wcnt_q == last_word_c) ? 3'(w_q - PW'(1)) : 3'd7;
      word_end_c  = (ccnt_q == ch_last_c) && (pcnt_q == last_px_c);
      line_end_c  = word_end_c && (wcnt_q == last_word_c);
      frame_end_c = line_end_c && (ycnt_q == h_q - PW'(1));
      pcnt_d      = pcnt_q;
      ccnt_d      = ccnt_q + CW'(1);
      if (ccnt_q == ch_last_c) begin
         ccnt_d = '0;
         pcnt_d = pcnt_q + 3'd1;
      end
   end

   // Accept only the lane of the current line; an abort cycle never pops a word
   always_comb begin
      sdata_rdy = '0;
      if ((state_q == S_LOAD) && sdata_vld[lcnt_q] && !frame_start)
         sdata_rdy[lcnt_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         w_q      <= '0;
         h_q      <= '0;
         ch_q     <= '0;
         wcnt_q   <= '0;
         ycnt_q   <= '0;
         lcnt_q   <= '0;
         pcnt_q   <= '0;
         ccnt_q   <= '0;
         hold_q   <= '0;
         out_vld  <= 1'b0;
         out_data <= 8'h00;
         out_sol  <= 1'b0;
         out_done <= 1'b0;
         busy     <= 1'b0;
      end else if (frame_start) begin
         // Start or abort-and-restart: both begin with a fresh filter byte
         state_q  <= S_FILT;
         w_q      <= pic_width;
         h_q      <= pic_height;
         ch_q     <= ch_clamp_c;
         wcnt_q   <= '0;
         ycnt_q   <= '0;
         lcnt_q   <= '0;
         pcnt_q   <= '0;
         ccnt_q   <= '0;
         out_vld  <= 1'b1;
         out_data <= 8'h00;
         out_sol  <= 1'b1;
         out_done <= 1'b0;
         busy     <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_FILT: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  out_sol <= 1'b0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (sdata_vld[lcnt_q]) begin
                  hold_q   <= sdata_a[lcnt_q];
                  out_data <= sdata_a[lcnt_q][0][0];
                  out_vld  <= 1'b1;
                  state_q  <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (out_rdy) begin
                  if (!word_end_c) begin
                     ccnt_q   <= ccnt_d;
                     pcnt_q   <= pcnt_d;
                     out_data <= hold_q[ccnt_d][pcnt_d];
                  end else begin
                     ccnt_q <= '0;
                     pcnt_q <= '0;
                     if (!line_end_c) begin
                        wcnt_q  <= wcnt_q + PW'(1);
                        out_vld <= 1'b0;
                        state_q <= S_LOAD;
                     end else begin
                        wcnt_q <= '0;
                        ycnt_q <= ycnt_q + PW'(1);
                        lcnt_q <= lcnt_q + LW'(1);
                        if (frame_end_c) begin
                           out_vld  <= 1'b0;
                           out_done <= 1'b1;
                           busy     <= 1'b0;
                           state_q  <= S_DONE;
                        end else begin
                           out_data <= 8'h00;
                           out_sol  <= 1'b1;
                           state_q  <= S_FILT;
                        end
                     end
                  end
               end
            end
            S_DONE: begin
               out_done <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
